onehot_encoder_stream: RTL and testbench

Parametrised, registered N:log2(N) encoder with a valid/ready stream interface on input and output. It replaces fixed-width combinational one-hot encoders in datapaths that need backpressure and deterministic handling of illegal input. A run-time-independent mode parameter selects one of three behaviours: strict one-hot, LSB-first priority, or MSB-first priority. A saturating counter records illegal input words for debug visibility.

---
 rtl/onehot_encoder_stream.sv | 149 ++++++++++++++
 tb/tb_onehot_encoder_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : onehot_encoder_stream
// Purpose  : Registered N:log2(N) encoder with valid/ready streaming on both
//            sides. MODE selects strict one-hot (0), lowest-bit priority (1)
//            or highest-bit priority (2). Illegal words are counted in a
//            saturating, clearable counter.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            in_valid/in_ready  - input handshake, in_data = request vector
//            out_valid/out_ready- output handshake
//            out_idx            - encoded index
//            out_zero/out_multi - no bit / more than one bit in accepted word
//            err_cnt, clr_cnt   - illegal-word counter and its sync clear
// Revision : 1.0 - initial release
// ============================================================================
module onehot_encoder_stream #(
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    // Derived from N; not intended to be overridden.
    parameter int W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_zero,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    localparam logic [N-1:0]     C_ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic             out_valid_q;
    logic [W-1:0]     out_idx_q;
    logic             out_zero_q;
    logic             out_multi_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic             w_in_xfer;
    logic             w_zero;
    logic             w_multi;
    logic             w_illegal;
    logic [W-1:0]     w_idx;

    // The only combinational path from out_ready to an output.
    assign in_ready  = !out_valid_q || out_ready;
    assign w_in_xfer = in_valid && in_ready;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_zero  = ~|in_data;
    assign w_multi = |(in_data & (in_data - C_ONE));

    generate
        if (MODE == 0) begin : g_strict
            logic [W-1:0] w_idx_or;

            // OR of the positions of all set bits; exact when one bit is set,
            // and masked to zero below for illegal words so no X escapes.
            always_comb begin
                w_idx_or = '0;
                for (int i = 0; i < N; i++) begin
                    if (in_data[i]) begin
                        w_idx_or = w_idx_or | W'(i);
                    end
                end
            end

            assign w_illegal = w_zero || w_multi;
            assign w_idx     = w_illegal ? '0 : w_idx_or;
        end else if (MODE == 1) begin : g_lsb_first
            logic [W-1:0] w_idx_lsb;

            // Scan downward so the lowest set bit is written last and wins.
            always_comb begin
                w_idx_lsb = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_data[i]) begin
                        w_idx_lsb = W'(i);
                    end
                end
            end

            assign w_illegal = w_zero;
            assign w_idx     = w_idx_lsb;
        end else begin : g_msb_first
            logic [W-1:0] w_idx_msb;

            // Scan upward so the highest set bit is written last and wins.
            always_comb begin
                w_idx_msb = '0;
                for (int i = 0; i < N; i++) begin
                    if (in_data[i]) begin
                        w_idx_msb = W'(i);
                    end
                end
            end

            assign w_illegal = w_zero;
            assign w_idx     = w_idx_msb;
        end
    endgenerate

    // Clear beats a coincident increment; increment stops at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (w_in_xfer && w_illegal && (err_cnt_q != C_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (w_in_xfer) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= w_idx;
                out_zero_q  <= w_zero;
                out_multi_q <= w_multi;
            end else if (out_ready) begin
                // Result fields keep their last values once drained.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_zero  = out_zero_q;
    assign out_multi = out_multi_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_encoder_stream
// Purpose  : Directed self-checking bench for onehot_encoder_stream using
//            four instances: N=8 strict, N=16 LSB-first, N=16 MSB-first and
//            N=8 strict with a 2-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder_stream;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    // Instance A: N=8, MODE 0, CNT_W=8
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data;
    logic [2:0] a_out_idx;
    logic       a_out_zero, a_out_multi, a_clr;
    logic [7:0] a_err_cnt;

    // Instances B (MODE 1) and C (MODE 2): N=16, shared inputs
    logic        bc_in_valid, bc_out_ready, bc_clr;
    logic [15:0] bc_in_data;
    logic        b_in_ready, b_out_valid, b_out_zero, b_out_multi;
    logic [3:0]  b_out_idx;
    logic [7:0]  b_err_cnt;
    logic        c_in_ready, c_out_valid, c_out_zero, c_out_multi;
    logic [3:0]  c_out_idx;
    logic [7:0]  c_err_cnt;

    // Instance D: N=8, MODE 0, CNT_W=2
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [7:0] d_in_data;
    logic [2:0] d_out_idx;
    logic       d_out_zero, d_out_multi, d_clr;
    logic [1:0] d_err_cnt;

    onehot_encoder_stream #(.N(8), .MODE(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_zero(a_out_zero), .out_multi(a_out_multi),
        .err_cnt(a_err_cnt), .clr_cnt(a_clr)
    );

    onehot_encoder_stream #(.N(16), .MODE(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(bc_in_valid), .in_ready(b_in_ready), .in_data(bc_in_data),
        .out_valid(b_out_valid), .out_ready(bc_out_ready), .out_idx(b_out_idx),
        .out_zero(b_out_zero), .out_multi(b_out_multi),
        .err_cnt(b_err_cnt), .clr_cnt(bc_clr)
    );

    onehot_encoder_stream #(.N(16), .MODE(2), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(bc_in_valid), .in_ready(c_in_ready), .in_data(bc_in_data),
        .out_valid(c_out_valid), .out_ready(bc_out_ready), .out_idx(c_out_idx),
        .out_zero(c_out_zero), .out_multi(c_out_multi),
        .err_cnt(c_err_cnt), .clr_cnt(bc_clr)
    );

    onehot_encoder_stream #(.N(8), .MODE(0), .CNT_W(2)) u_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_idx(d_out_idx),
        .out_zero(d_out_zero), .out_multi(d_out_multi),
        .err_cnt(d_err_cnt), .clr_cnt(d_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1; a_clr = 0;
        bc_in_valid = 0; bc_in_data = '0; bc_out_ready = 1; bc_clr = 0;
        d_in_valid = 0; d_in_data = '0; d_out_ready = 1; d_clr = 0;
        #12;
        n_vec++;
        if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt, a_in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_a: got v=%b idx=%0d z=%b m=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1",
                     a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt, a_in_ready);
        end
        n_vec++;
        if ({b_out_valid, b_out_idx, b_err_cnt, c_out_valid, c_out_idx, c_err_cnt, d_out_valid, d_err_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_bcd: got b=%b/%0d/%0d c=%b/%0d/%0d d=%b/%0d, want all 0",
                     b_out_valid, b_out_idx, b_err_cnt, c_out_valid, c_out_idx, c_err_cnt, d_out_valid, d_err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream_onehot();
        a_out_ready = 1;
        a_in_valid  = 1;
        a_in_data   = 8'h01;
        for (int i = 0; i < 8; i++) begin
            a_in_data = 8'(1 << i);
            step();
            n_vec++;
            if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt} !== {1'b1, 3'(i), 1'b0, 1'b0, 8'd0}) begin
                n_err++;
                $display("FAIL stream_onehot[%0d]: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 %0d 0 0 0",
                         i, a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt, i);
            end
        end
        a_in_valid = 0;
        step();
        n_vec++;
        if (a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: got out_valid=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_illegal_strict();
        a_in_valid = 1;
        a_in_data  = 8'h00;
        step();
        n_vec++;
        if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt} !== {1'b1, 3'd0, 1'b1, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL strict_zero: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 0 1 0 1",
                     a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt);
        end
        a_in_data = 8'h14;
        step();
        n_vec++;
        if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt} !== {1'b1, 3'd0, 1'b0, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL strict_multi: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 0 0 1 2",
                     a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt);
        end
        a_in_valid = 0;
        step();
    endtask

    task automatic test_priority_modes();
        logic [15:0] vec  [4] = '{16'h0A50, 16'h8000, 16'h0001, 16'h0000};
        logic [3:0]  lsb  [4] = '{4'd4, 4'd15, 4'd0, 4'd0};
        logic [3:0]  msb  [4] = '{4'd11, 4'd15, 4'd0, 4'd0};
        logic        mul  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        zro  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0]  cnt  [4] = '{8'd0, 8'd0, 8'd0, 8'd1};
        bc_out_ready = 1;
        bc_in_valid  = 1;
        for (int i = 0; i < 4; i++) begin
            bc_in_data = vec[i];
            step();
            n_vec++;
            if ({b_out_valid, b_out_idx, b_out_zero, b_out_multi, b_err_cnt} !== {1'b1, lsb[i], zro[i], mul[i], cnt[i]}) begin
                n_err++;
                $display("FAIL lsb_first[%h]: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 %0d %b %b %0d",
                         vec[i], b_out_valid, b_out_idx, b_out_zero, b_out_multi, b_err_cnt, lsb[i], zro[i], mul[i], cnt[i]);
            end
            n_vec++;
            if ({c_out_valid, c_out_idx, c_out_zero, c_out_multi, c_err_cnt} !== {1'b1, msb[i], zro[i], mul[i], cnt[i]}) begin
                n_err++;
                $display("FAIL msb_first[%h]: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 %0d %b %b %0d",
                         vec[i], c_out_valid, c_out_idx, c_out_zero, c_out_multi, c_err_cnt, msb[i], zro[i], mul[i], cnt[i]);
            end
        end
        bc_in_valid = 0;
        step();
        n_vec++;
        if ({b_out_valid, c_out_valid, b_in_ready, c_in_ready} !== 4'b0011) begin
            n_err++;
            $display("FAIL prio_drain: got bv=%b cv=%b br=%b cr=%b, want 0 0 1 1",
                     b_out_valid, c_out_valid, b_in_ready, c_in_ready);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 8'h08;
        step();
        // Words offered while stalled must be ignored.
        a_in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_in_ready, a_err_cnt} !== {1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd2}) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got v=%b idx=%0d z=%b m=%b rdy=%b cnt=%0d, want 1 3 0 0 0 2",
                         i, a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_in_ready, a_err_cnt);
            end
            step();
        end
        a_out_ready = 1;
        a_in_data   = 8'h40;
        #1;
        n_vec++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release_ready: got in_ready=%b, want 1", a_in_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({a_out_valid, a_out_idx, a_err_cnt} !== {1'b1, 3'd6, 8'd2}) begin
            n_err++;
            $display("FAIL backpressure_next: got v=%b idx=%0d cnt=%0d, want 1 6 2",
                     a_out_valid, a_out_idx, a_err_cnt);
        end
        a_in_valid = 0;
        step();
    endtask

    task automatic test_counter_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        d_out_ready = 1;
        d_in_valid  = 1;
        d_in_data   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if ({d_err_cnt, d_out_zero} !== {exp_cnt[i], 1'b1}) begin
                n_err++;
                $display("FAIL counter_sat[%0d]: got cnt=%0d z=%b, want %0d 1",
                         i, d_err_cnt, d_out_zero, exp_cnt[i]);
            end
        end
        d_clr = 1;
        step();
        n_vec++;
        if ({d_err_cnt, d_out_valid, d_in_ready} !== {2'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL counter_clear: got cnt=%0d v=%b rdy=%b, want 0 1 1",
                     d_err_cnt, d_out_valid, d_in_ready);
        end
        d_clr = 0;
        d_in_data = 8'h81;
        step();
        n_vec++;
        if ({d_err_cnt, d_out_multi, d_out_idx} !== {2'd1, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL counter_after_clear: got cnt=%0d m=%b idx=%0d, want 1 1 0",
                     d_err_cnt, d_out_multi, d_out_idx);
        end
        d_in_valid = 0;
        step();
    endtask

    task automatic test_async_reset();
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 8'h20;
        step();
        a_in_valid = 0;
        n_vec++;
        if ({a_out_valid, a_out_idx, a_err_cnt} !== {1'b1, 3'd5, 8'd2}) begin
            n_err++;
            $display("FAIL pre_reset: got v=%b idx=%0d cnt=%0d, want 1 5 2",
                     a_out_valid, a_out_idx, a_err_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt, a_in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b idx=%0d z=%b m=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1",
                     a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt, a_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1;
        a_in_valid  = 1;
        a_in_data   = 8'h04;
        step();
        n_vec++;
        if ({a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt} !== {1'b1, 3'd2, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL post_reset: got v=%b idx=%0d z=%b m=%b cnt=%0d, want 1 2 0 0 0",
                     a_out_valid, a_out_idx, a_out_zero, a_out_multi, a_err_cnt);
        end
        a_in_valid = 0;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_stream_onehot();
        test_illegal_strict();
        test_priority_modes();
        test_backpressure();
        test_counter_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
